// File: rtl/hs_fifo_buffer_pkg.sv
// Shared constants and helpers for the handshake FIFO buffer.
// Provides default payload width, default depth and the pointer-width function.
package hs_pkg;

    localparam int unsigned default_data_width = 32;
    localparam int unsigned default_depth      = 8;

    // A depth of one would give a zero-width pointer; clamp to one bit.
    function automatic int unsigned ptr_width(input int unsigned d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/hs_fifo_buffer_if.sv
// Upstream/downstream request-acknowledge bundle for hs_fifo_buffer.
// The master modport is the buffer side, the slave modport is the surrounding system.
interface hs_fifo_buffer_if
    import hs_pkg::*;
#(
    parameter int unsigned data_width = default_data_width
);

    logic                  up_req;
    logic                  up_ack;
    logic [data_width-1:0] up_din;
    logic                  dn_req;
    logic                  dn_ack;
    logic [data_width-1:0] dn_dout;

    modport master (
        output up_req,
        input  up_ack,
        input  up_din,
        input  dn_req,
        output dn_ack,
        output dn_dout
    );

    modport slave (
        input  up_req,
        output up_ack,
        output up_din,
        output dn_req,
        input  dn_ack,
        input  dn_dout
    );

endinterface

// File: rtl/hs_fifo_buffer_mem.sv
// Storage array for hs_fifo_buffer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the control logic decides which entries are live.
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int unsigned data_width = default_data_width,
    parameter int unsigned depth      = default_depth
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ptr_width(depth)-1:0]   wr_addr,
    input  logic [data_width-1:0]         wr_data,
    input  logic [ptr_width(depth)-1:0]   rd_addr,
    output logic [data_width-1:0]         rd_data
);

    logic [data_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/hs_fifo_buffer.sv
// Request/acknowledge FIFO buffer: upstream writes on up_ack, downstream gets one-cycle dn_ack pulses.
// Optional 32-bit transfer counters stat_in/stat_out are built when HS_FIFO_STATS_EN is defined.
module hs_fifo_buffer
    import hs_pkg::*;
#(
    parameter int unsigned data_width = default_data_width,
    parameter int unsigned depth      = default_depth
) (
    input  logic                     clk,
    input  logic                     rst,
    hs_fifo_buffer_if.master         bus,
    output logic [$clog2(depth):0]   occupancy,
    output logic                     err_overflow
`ifdef HS_FIFO_STATS_EN
    ,
    output logic [31:0]              stat_in,
    output logic [31:0]              stat_out
`endif
);

    localparam int unsigned pw = ptr_width(depth);
    localparam int unsigned ow = $clog2(depth) + 1;

    localparam logic [ow-1:0] occ_full = ow'(depth);
    localparam logic [ow-1:0] occ_one  = ow'(1);
    localparam logic [pw-1:0] ptr_one  = pw'(1);

    generate
        if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
            $error("hs_fifo_buffer: depth must be a power of two and at least 2");
        end
    endgenerate

    logic [pw-1:0]         wr_ptr_q, wr_ptr_d;
    logic [pw-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ow-1:0]         occ_q, occ_d;
    logic                  up_req_q, up_req_d;
    logic                  dn_ack_q, dn_ack_d;
    logic [data_width-1:0] dn_dout_q, dn_dout_d;
    logic                  err_q, err_d;
    logic [data_width-1:0] head_data;
    logic                  wr_en;
    logic                  rd_en;

    hs_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.up_din),
        .rd_addr (rd_ptr_q),
        .rd_data (head_data)
    );

    // A read is never issued the cycle after an acknowledge, which caps output at one item per two cycles.
    // A write while full is accepted only if the same edge frees a slot; otherwise it is dropped and flagged.
    always_comb begin
        rd_en     = bus.dn_req && !dn_ack_q && (occ_q != '0);
        wr_en     = bus.up_ack && ((occ_q != occ_full) || rd_en);

        wr_ptr_d  = wr_en ? (wr_ptr_q + ptr_one) : wr_ptr_q;
        rd_ptr_d  = rd_en ? (rd_ptr_q + ptr_one) : rd_ptr_q;

        occ_d     = occ_q;
        if (wr_en && !rd_en) begin
            occ_d = occ_q + occ_one;
        end else if (!wr_en && rd_en) begin
            occ_d = occ_q - occ_one;
        end

        up_req_d  = (occ_d < occ_full);
        dn_ack_d  = rd_en;
        dn_dout_d = rd_en ? head_data : dn_dout_q;
        err_d     = err_q || (bus.up_ack && !wr_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            up_req_q  <= 1'b0;
            dn_ack_q  <= 1'b0;
            dn_dout_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            up_req_q  <= up_req_d;
            dn_ack_q  <= dn_ack_d;
            dn_dout_q <= dn_dout_d;
            err_q     <= err_d;
        end
    end

    assign bus.up_req   = up_req_q;
    assign bus.dn_ack   = dn_ack_q;
    assign bus.dn_dout  = dn_dout_q;
    assign occupancy    = occ_q;
    assign err_overflow = err_q;

`ifdef HS_FIFO_STATS_EN
    logic [31:0] stat_in_q, stat_in_d;
    logic [31:0] stat_out_q, stat_out_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stat_in_d  = wr_en ? (stat_in_q + 32'd1) : stat_in_q;
        stat_out_d = rd_en ? (stat_out_q + 32'd1) : stat_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_in_q  <= '0;
            stat_out_q <= '0;
        end else begin
            stat_in_q  <= stat_in_d;
            stat_out_q <= stat_out_d;
        end
    end

    assign stat_in  = stat_in_q;
    assign stat_out = stat_out_q;
`endif

endmodule

// File: tb/tb_hs_fifo_buffer.sv
// Directed self-checking bench for hs_fifo_buffer (depth 8, 32-bit payload).
// Stat counter checks are compiled in only when HS_FIFO_STATS_EN is defined.
module tb_hs_fifo_buffer;
    import hs_pkg::*;

    logic clk;
    logic rst;
    logic [3:0] occupancy;
    logic err_overflow;
`ifdef HS_FIFO_STATS_EN
    logic [31:0] stat_in;
    logic [31:0] stat_out;
`endif

    hs_fifo_buffer_if #(.data_width(32)) bus ();

    hs_fifo_buffer #(
        .data_width (32),
        .depth      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .occupancy    (occupancy),
        .err_overflow (err_overflow)
`ifdef HS_FIFO_STATS_EN
        ,
        .stat_in      (stat_in),
        .stat_out     (stat_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int s_sent, s_got, s_oerr, s_first, s_last;
    bit s_consec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Producer acks whenever up_req & ~up_ack; consumer optionally holds dn_req high.
    // Every dn_ack is checked against base+index; stops once n written and rx_n received or budget expires.
    task automatic run_stream(input int n, input int base, input bit consume, input int rx_n,
                              input int budget);
        bit prev_ack;
        prev_ack = 1'b0;
        s_sent = 0; s_got = 0; s_oerr = 0; s_first = -1; s_last = -1; s_consec = 1'b0;
        bus.dn_req = consume;
        bus.up_ack = (n > 0) && bus.up_req;
        bus.up_din = 32'(base);
        for (int cyc = 0; cyc < budget; cyc++) begin
            tick();
            if (bus.up_ack) s_sent++;
            if (bus.dn_ack) begin
                if (prev_ack) s_consec = 1'b1;
                if (bus.dn_dout !== 32'(base + s_got)) s_oerr++;
                if (s_first < 0) s_first = cyc;
                s_last = cyc;
                s_got++;
            end
            prev_ack   = bus.dn_ack;
            bus.up_ack = (s_sent < n) && bus.up_req && !bus.up_ack;
            bus.up_din = 32'(base + s_sent);
            if (s_sent >= n && s_got >= rx_n) break;
        end
        bus.up_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.up_ack = 1'b0; bus.up_din = '0; bus.dn_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (bus.up_req !== 1'b0) $display("FAIL reset_up_req got=%b exp=0", bus.up_req); else pass_cnt++;
        total_cnt++; if (bus.dn_ack !== 1'b0) $display("FAIL reset_dn_ack got=%b exp=0", bus.dn_ack); else pass_cnt++;
        total_cnt++; if (bus.dn_dout !== 32'd0) $display("FAIL reset_dn_dout got=%h exp=0", bus.dn_dout); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy); else pass_cnt++;
        total_cnt++; if (err_overflow !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_overflow); else pass_cnt++;
        tick(); tick();
        @(negedge clk) rst = 1'b0;
        tick();
        total_cnt++; if (bus.up_req !== 1'b1) $display("FAIL reset_release_up_req got=%b exp=1", bus.up_req); else pass_cnt++;
        $display("reset: checks done");
    endtask

    task automatic test_stream();
        run_stream(20, 0, 1'b1, 20, 200);
        total_cnt++; if (s_got !== 20) $display("FAIL stream_count got=%0d exp=20", s_got); else pass_cnt++;
        total_cnt++; if (s_oerr !== 0) $display("FAIL stream_order got=%0d bad exp=0", s_oerr); else pass_cnt++;
        total_cnt++; if (s_consec !== 1'b0) $display("FAIL stream_ack_consec got=%b exp=0", s_consec); else pass_cnt++;
        total_cnt++; if (err_overflow !== 1'b0) $display("FAIL stream_err got=%b exp=0", err_overflow); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd0) $display("FAIL stream_occ_end got=%0d exp=0", occupancy); else pass_cnt++;
        $display("stream: 20 items, received %0d", s_got);
    endtask

    task automatic test_fill();
        run_stream(8, 100, 1'b0, 0, 100);
        total_cnt++; if (s_sent !== 8) $display("FAIL fill_sent got=%0d exp=8", s_sent); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd8) $display("FAIL fill_occ got=%0d exp=8", occupancy); else pass_cnt++;
        total_cnt++; if (bus.up_req !== 1'b0) $display("FAIL fill_up_req got=%b exp=0", bus.up_req); else pass_cnt++;
        total_cnt++; if (err_overflow !== 1'b0) $display("FAIL fill_err got=%b exp=0", err_overflow); else pass_cnt++;
        $display("fill: occupancy %0d", occupancy);
    endtask

    task automatic test_single_read();
        bus.dn_req = 1'b1;
        tick();
        bus.dn_req = 1'b0;
        total_cnt++; if (bus.dn_ack !== 1'b1) $display("FAIL single_ack got=%b exp=1", bus.dn_ack); else pass_cnt++;
        total_cnt++; if (bus.dn_dout !== 32'd100) $display("FAIL single_data got=%0d exp=100", bus.dn_dout); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd7) $display("FAIL single_occ got=%0d exp=7", occupancy); else pass_cnt++;
        total_cnt++; if (bus.up_req !== 1'b1) $display("FAIL single_up_req got=%b exp=1", bus.up_req); else pass_cnt++;
        tick();
        total_cnt++; if (bus.dn_ack !== 1'b0) $display("FAIL single_ack_pulse got=%b exp=0", bus.dn_ack); else pass_cnt++;
        total_cnt++; if (bus.dn_dout !== 32'd100) $display("FAIL single_data_hold got=%0d exp=100", bus.dn_dout); else pass_cnt++;
        bus.up_ack = 1'b1; bus.up_din = 32'd108;
        tick();
        bus.up_ack = 1'b0;
        total_cnt++; if (occupancy !== 4'd8) $display("FAIL refill_occ got=%0d exp=8", occupancy); else pass_cnt++;
        $display("single_read: got %0d, occupancy now %0d", 100, occupancy);
    endtask

    task automatic test_overflow();
        bus.dn_req = 1'b0;
        bus.up_ack = 1'b1; bus.up_din = 32'hDEAD_BEEF;
        tick();
        bus.up_ack = 1'b0;
        total_cnt++; if (err_overflow !== 1'b1) $display("FAIL ovf_err got=%b exp=1", err_overflow); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd8) $display("FAIL ovf_occ got=%0d exp=8", occupancy); else pass_cnt++;
        total_cnt++; if (bus.up_req !== 1'b0) $display("FAIL ovf_up_req got=%b exp=0", bus.up_req); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", err_overflow); else pass_cnt++;
        run_stream(0, 101, 1'b1, 8, 60);
        total_cnt++; if (s_got !== 8) $display("FAIL drain_count got=%0d exp=8", s_got); else pass_cnt++;
        total_cnt++; if (s_oerr !== 0) $display("FAIL drain_order got=%0d bad exp=0", s_oerr); else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (bus.dn_ack !== 1'b0) $display("FAIL empty_no_ack got=%b exp=0", bus.dn_ack); else pass_cnt++;
        total_cnt++; if (bus.dn_dout !== 32'd108) $display("FAIL empty_dout_hold got=%0d exp=108", bus.dn_dout); else pass_cnt++;
        total_cnt++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky_end got=%b exp=1", err_overflow); else pass_cnt++;
        bus.dn_req = 1'b0;
        $display("overflow: drained %0d items, err=%b", s_got, err_overflow);
    endtask

    task automatic test_reset_mid();
        run_stream(5, 200, 1'b0, 0, 50);
        total_cnt++; if (occupancy !== 4'd5) $display("FAIL mid_occ_before got=%0d exp=5", occupancy); else pass_cnt++;
        #3;
        bus.up_ack = 1'b1; bus.up_din = 32'h0BAD_0BAD;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.up_req !== 1'b0) $display("FAIL mid_up_req got=%b exp=0", bus.up_req); else pass_cnt++;
        total_cnt++; if (bus.dn_dout !== 32'd0) $display("FAIL mid_dout got=%h exp=0", bus.dn_dout); else pass_cnt++;
        total_cnt++; if (occupancy !== 4'd0) $display("FAIL mid_occ got=%0d exp=0", occupancy); else pass_cnt++;
        total_cnt++; if (err_overflow !== 1'b0) $display("FAIL mid_err got=%b exp=0", err_overflow); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (occupancy !== 4'd0) $display("FAIL mid_ack_ignored got=%0d exp=0", occupancy); else pass_cnt++;
        bus.up_ack = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        total_cnt++; if (bus.up_req !== 1'b1) $display("FAIL mid_release_up_req got=%b exp=1", bus.up_req); else pass_cnt++;
        run_stream(3, 300, 1'b1, 3, 50);
        total_cnt++; if (s_got !== 3) $display("FAIL mid_after_count got=%0d exp=3", s_got); else pass_cnt++;
        total_cnt++; if (s_oerr !== 0) $display("FAIL mid_after_order got=%0d bad exp=0", s_oerr); else pass_cnt++;
        bus.dn_req = 1'b0;
        $display("reset_mid: %0d fresh items after reset", s_got);
    endtask

    task automatic test_throughput();
        rst = 1'b1;
        tick();
        @(negedge clk) rst = 1'b0;
        tick();
        run_stream(5000, 1000, 1'b1, 5000, 12000);
        total_cnt++; if (s_got !== 5000) $display("FAIL tput_count got=%0d exp=5000", s_got); else pass_cnt++;
        total_cnt++; if (s_oerr !== 0) $display("FAIL tput_order got=%0d bad exp=0", s_oerr); else pass_cnt++;
        total_cnt++; if ((s_last - s_first) !== 9998) $display("FAIL tput_span got=%0d exp=9998", s_last - s_first); else pass_cnt++;
        total_cnt++; if (s_consec !== 1'b0) $display("FAIL tput_ack_consec got=%b exp=0", s_consec); else pass_cnt++;
`ifdef HS_FIFO_STATS_EN
        total_cnt++; if (stat_in !== 32'd5000) $display("FAIL stat_in got=%0d exp=5000", stat_in); else pass_cnt++;
        total_cnt++; if (stat_out !== 32'd5000) $display("FAIL stat_out got=%0d exp=5000", stat_out); else pass_cnt++;
`endif
        bus.dn_req = 1'b0;
        $display("throughput: %0d items over %0d edges", s_got, s_last - s_first);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_single_read();
        test_overflow();
        test_reset_mid();
        test_throughput();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hs_fifo_buffer.md
HS_FIFO_BUFFER -- requirements
Module: hs_fifo_buffer

Interface
REQ-001 The block SHALL have parameter data_width, default 32, meaning the payload width in bits.
REQ-002 The block SHALL have parameter depth, default 8, meaning the number of storage entries; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have input clk, 1 bit, the single clock.
REQ-004 The block SHALL have input rst, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have output up_req, 1 bit, a registered request to the upstream producer.
REQ-006 The block SHALL have input up_ack, 1 bit, the producer acknowledge; up_din is valid in the same cycle.
REQ-007 The block SHALL have input up_din, data_width bits, the upstream payload.
REQ-008 The block SHALL have input dn_req, 1 bit, the request from the downstream consumer or operator.
REQ-009 The block SHALL have output dn_ack, 1 bit, a registered single-cycle acknowledge to downstream.
REQ-010 The block SHALL have output dn_dout, data_width bits, the payload; it is valid while dn_ack=1.
REQ-011 The block SHALL have output occupancy, $clog2(depth)+1 bits, the current number of stored entries.
REQ-012 The block SHALL have output err_overflow, 1 bit, a sticky flag set when up_ack arrives while the buffer is full.

Function
REQ-013 Write: on each rising edge with up_ack=1 and occupancy<depth, up_din SHALL be stored at the write pointer, and the write pointer SHALL increment modulo depth.
REQ-014 Read: on a rising edge with dn_req=1, dn_ack=0 and occupancy>0, the block SHALL set dn_ack to 1, load dn_dout from the head entry, and increment the read pointer modulo depth.
REQ-015 dn_ack SHALL be 1 for exactly one cycle per transfer and SHALL never be 1 in two consecutive cycles, so the maximum rate is one item per 2 cycles.
REQ-016 Occupancy SHALL update as occ_next = occ + write - read; a simultaneous read and write SHALL leave occupancy unchanged.
REQ-017 up_req SHALL be registered as up_req <= (occ_next < depth) on every edge.
REQ-018 Latency: an item written at edge E SHALL be acknowledged downstream no earlier than edge E+1, given that dn_req is held high.
REQ-019 Full case: if up_ack=1 while occupancy=depth and no read occurs on that edge, the data SHALL be dropped, err_overflow SHALL be set to 1 and held until reset, and no state other than err_overflow SHALL change.
REQ-020 Empty case: dn_req=1 with occupancy=0 SHALL produce no dn_ack, and dn_dout SHALL hold its last value.
REQ-021 Ordering SHALL be strict FIFO, with no reordering across pointer wrap-around.
REQ-022 dn_dout SHALL change only on edges where dn_ack rises.

Reset
REQ-023 While rst=1, the block SHALL immediately hold up_req=0, dn_ack=0, dn_dout=0, occupancy=0, both pointers=0 and err_overflow=0.
REQ-024 Reset asserted mid-transfer SHALL discard all stored and in-flight items; an up_ack seen while rst=1 SHALL be ignored.
REQ-025 On the first edge after rst falls, up_req SHALL go to 1.
REQ-026 Storage contents SHALL NOT require reset.

Configuration
REQ-027 With macro HS_FIFO_STATS_EN defined, the block SHALL add outputs stat_in and stat_out, each 32 bits, counting accepted writes and completed reads; both SHALL be cleared by rst and SHALL wrap at 2^32.
REQ-028 Without HS_FIFO_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Shared package hs_pkg SHALL hold the default data width (32), the default depth (8) and the pointer-width function.
REQ-030 Storage SHALL be a sub-module hs_fifo_mem with one write port and one read port, an unregistered read, and no reset.
REQ-031 Control logic (pointers, occupancy, handshake registers, error flag) SHALL reside in hs_fifo_buffer.

Verification
REQ-032 The bench SHALL cover: reset then a producer that acks whenever req & ~ack, with values 0..19 and dn_req held high, giving consumer output 0..19 in order with no error.
REQ-033 The bench SHALL cover: dn_req held at 0, producer running, giving occupancy=8 and up_req=0 one edge after the 8th write, and err_overflow=0.
REQ-034 The bench SHALL cover: a full buffer, then dn_req=1 for 1 cycle, giving one dn_ack carrying the first value, occupancy=7, and up_req=1 on the next edge.
REQ-035 The bench SHALL cover: a forced up_ack while full, giving err_overflow=1 sticky, occupancy still 8, and the dropped value never appearing downstream.
REQ-036 The bench SHALL cover: rst pulsed with occupancy=5, giving all outputs 0 immediately, and values written afterwards emerging first with no stale data.
REQ-037 The bench SHALL cover: HS_FIFO_STATS_EN defined and 5000 items transferred, giving stat_in=stat_out=5000 and measured throughput of 50% of clk edges.
